// File: rtl/execute_muldiv.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit for the EX stage.
// Define MULDIV_FAST_MUL_EN to route multiplies through a single-cycle combinational multiplier.
module execute_muldiv #(
   parameter int XLEN = 32,
   parameter int CNTW = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [4:0]      reg_write,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] dest,
   output logic [4:0]      reg_write_out
);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic            neg_q, neg_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] dest_q, dest_d;
   logic [4:0]      rdo_q, rdo_d;
   logic            done_q, done_d;

   logic            signed1, signed2, neg_in;
   logic [XLEN-1:0] mag1, mag2;
   logic [XLEN:0]   mul_sum, div_shift, div_trial;
   logic [XLEN-1:0] hi_n, lo_n;

   // Operands are reduced to magnitudes; the result sign is reapplied once at the end.
   assign signed1 = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
   assign signed2 = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
   assign mag1    = (signed1 && src1[XLEN-1]) ? -src1 : src1;
   assign mag2    = (signed2 && src2[XLEN-1]) ? -src2 : src2;
   // A zero divisor must leave the quotient all ones, so it never gets negated.
   assign neg_in  = op[2] ? (op[1] ? (signed1 && src1[XLEN-1])
                                   : (((signed1 && src1[XLEN-1]) ^ (signed2 && src2[XLEN-1])) && (|src2)))
                          : ((signed1 && src1[XLEN-1]) ^ (signed2 && src2[XLEN-1]));

   // hi:lo is the product accumulator for multiplies and remainder:quotient for divides.
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_trial = div_shift - {1'b0, b_q};
   assign hi_n = op_q[2] ? (div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0])
                         : mul_sum[XLEN:1];
   assign lo_n = op_q[2] ? {lo_q[XLEN-2:0], ~div_trial[XLEN]}
                         : {mul_sum[0], lo_q[XLEN-1:1]};

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

   function automatic logic [XLEN-1:0] finalize(input logic [2:0] f, input logic neg,
                                                input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   res;
      prod = neg ? -{hi, lo} : {hi, lo};
      if (!f[2])      res = (f[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else if (!f[1]) res = neg ? -lo : lo;
      else            res = neg ? -hi : hi;
      return res;
   endfunction

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rd_d    = rd_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      dest_d  = dest_q;
      rdo_d   = rdo_q;
      done_d  = done_q;
      if (kill) begin
         state_d = IDLE;
         done_d  = 1'b0;
         cnt_d   = '0;
      end else if (en) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_d  = op;
                  rd_d  = reg_write;
                  neg_d = neg_in;
                  cnt_d = '0;
                  hi_d  = '0;
                  lo_d  = op[2] ? mag1 : mag2;
                  b_d   = op[2] ? mag2 : mag1;
`ifdef MULDIV_FAST_MUL_EN
                  if (!op[2]) begin
                     state_d = FIN;
                     dest_d  = finalize(op, neg_in, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
                     rdo_d   = reg_write;
                     done_d  = 1'b1;
                  end else begin
                     state_d = CALC;
                  end
`else
                  state_d = CALC;
`endif
               end
            end
            CALC: begin
               hi_d  = hi_n;
               lo_d  = lo_n;
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == CNTW'(XLEN - 1)) begin
                  state_d = FIN;
                  cnt_d   = '0;
                  dest_d  = finalize(op_q, neg_q, hi_n, lo_n);
                  rdo_d   = rd_q;
                  done_d  = 1'b1;
               end
            end
            FIN: begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         dest_q  <= '0;
         rdo_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         dest_q  <= dest_d;
         rdo_q   <= rdo_d;
         done_q  <= done_d;
      end
   end

   assign busy          = (state_q == CALC);
   assign done          = done_q;
   assign dest          = dest_q;
   assign reg_write_out = rdo_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv (XLEN=32): directed corner cases plus random ops against an arithmetic model.
module tb_execute_muldiv;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, en, start, kill;
   logic [2:0]  op;
   logic [31:0] src1, src2;
   logic [4:0]  reg_write;
   logic        busy, done;
   logic [31:0] dest;
   logic [4:0]  reg_write_out;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_dest = '0;

   execute_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .kill(kill), .op(op),
      .src1(src1), .src2(src2), .reg_write(reg_write), .busy(busy), .done(done),
      .dest(dest), .reg_write_out(reg_write_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference results straight from the RV32M definitions using 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub, sp;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      up = {32'b0, a} * {32'b0, b};
      case (f)
         3'd0: return up[31:0];
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * ub; return sp[63:32]; end
         3'd3: return up[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            sp = sa / sb;
            return sp[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            sp = sa % sb;
            return sp[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      op = f; src1 = a; src2 = b; reg_write = rd;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // lat is the cycle (counted from the issue edge) in which done was seen.
   task automatic wait_done(input int c0, output int lat, output int nb);
      lat = c0;
      nb  = 0;
      while (done !== 1'b1 && lat < c0 + 100) begin
         nb += int'(busy);
         tick();
         lat++;
      end
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      int          lat, nb, exp_lat;
      logic [31:0] exp;
      exp     = ref_model(f, a, b);
      exp_lat = (FAST && !f[2]) ? 1 : 33;
      issue(f, a, b, rd);
      wait_done(1, lat, nb);
      check("latency", lat, exp_lat);
      check("dest", dest, exp);
      check("rd_out", reg_write_out, rd);
      check("busy_at_done", busy, 0);
      check("busy_cycles", nb, exp_lat - 1);
      $display("op=%0d src1=%h src2=%h rd=%0d dest=%h exp=%h lat=%0d", f, a, b, rd, dest, exp, lat);
      last_dest = exp;
      tick();
      check("done_pulse", done, 0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat, nb, ndone;
      rst = 1'b1; en = 1'b1; start = 1'b0; kill = 1'b0;
      op = '0; src1 = '0; src2 = '0; reg_write = '0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dest", dest, 0);
      check("rst_rd", reg_write_out, 0);
      rst = 1'b0;
      tick();

      do_op(3'd0, 32'd7, 32'd6, 5'd5);
      do_op(3'd1, 32'h8000_0000, 32'd2, 5'd1);
      do_op(3'd3, 32'h8000_0000, 32'd2, 5'd2);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      do_op(3'd4, -32'sd7, 32'd2, 5'd4);
      do_op(3'd6, -32'sd7, 32'd2, 5'd6);
      do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7);
      for (int i = 4; i < 8; i++) do_op(3'(i), 32'd9, 32'd0, 5'(i + 8));
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21);

      // Stall for three cycles mid-calculation and try a second issue while busy.
      issue(3'd5, 32'd100, 32'd7, 5'd3);
      lat = 1;
      repeat (5) begin tick(); lat++; end
      en = 1'b0;
      repeat (3) begin tick(); lat++; end
      en = 1'b1;
      op = 3'd0; src1 = 32'd3; src2 = 32'd3; reg_write = 5'd30; start = 1'b1;
      tick(); lat++;
      start = 1'b0;
      wait_done(lat, lat, nb);
      check("stall_latency", lat, 36);
      check("stall_dest", dest, 14);
      check("stall_rd", reg_write_out, 3);
      $display("op=5 src1=00000064 src2=00000007 rd=3 dest=%h exp=0000000e lat=%0d (stalled)", dest, lat);
      last_dest = 32'd14;
      ndone = 0;
      repeat (40) begin tick(); ndone += int'(done); end
      check("no_second_done", ndone, 0);

      // Issue attempted in the done cycle must be ignored.
      issue(3'd5, 32'd20, 32'd3, 5'd6);
      wait_done(1, lat, nb);
      check("fin_lat", lat, 33);
      check("fin_dest", dest, 6);
      last_dest = 32'd6;
      op = 3'd0; src1 = 32'd2; src2 = 32'd2; reg_write = 5'd1; start = 1'b1;
      tick();
      start = 1'b0;
      check("fin_start_busy", busy, 0);
      check("fin_start_done", done, 0);
      $display("op=5 src1=00000014 src2=00000003 rd=6 dest=%h exp=00000006 lat=%0d (start in done cycle)", dest, lat);
      repeat (3) tick();

      // Kill at cycle 10 of a divide.
      issue(3'd4, -32'sd100, 32'd7, 5'd9);
      repeat (9) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill_busy", busy, 0);
      ndone = 0;
      repeat (40) begin tick(); ndone += int'(done); end
      check("kill_no_done", ndone, 0);
      check("kill_dest", dest, last_dest);
      $display("op=4 killed at cycle 10 dest=%h", dest);

      // Kill on the edge that would raise done.
      issue(3'd5, 32'd50, 32'd5, 5'd4);
      repeat (31) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("late_kill_done", done, 0);
      check("late_kill_busy", busy, 0);
      check("late_kill_dest", dest, last_dest);
      $display("op=5 killed on final edge dest=%h", dest);
      repeat (3) tick();

      // Reset mid-operation.
      issue(3'd5, 32'd77, 32'd3, 5'd12);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_dest", dest, 0);
      check("mid_rst_rd", reg_write_out, 0);
      $display("reset at cycle 5 dest=%h rd_out=%0d", dest, reg_write_out);
      last_dest = '0;
      do_op(3'd0, 32'd3, 32'd3, 5'd8);

      for (int i = 0; i < 40; i++)
         do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
